// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package myPkg;

  // Scanner states: free scanning, press qualification, key down, release qualification.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Key code {row_idx, col_idx}; doubles as a hex digit for the display path.
  typedef logic [3:0] kp_code_t;

  // Index of the lowest active-low row bit; only meaningful when some bit is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next-state: shift the asynchronous input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages; reset to the idle level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, key code strobe.
module keypad_scan
  import myPkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT - 1);

  logic [3:0] rs;

  sync2 #(
    .WIDTH  (4),
    .RST_VAL(4'b1111)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (row),
    .q  (rs)
  );

  kp_state_t     state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [MW-1:0] match_q, match_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    col_q, col_d;
  kp_code_t      key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          sample;
  logic          rs_low;
  logic [1:0]    rs_idx;
  logic          row_hit;
  logic          cap_high;

  // Sample-point detection and decoding of the synchronized rows.
  always_comb begin
    sample   = (dwell_q == DWELL_LAST);
    rs_low   = (rs != 4'b1111);
    rs_idx   = lowest_low(rs);
    row_hit  = rs_low && (rs_idx == row_idx_q);
    cap_high = rs[row_idx_q];
  end

  // Next-state logic for the dwell counter, the scan FSM and its outputs.
  always_comb begin
    state_d     = state_q;
    dwell_d     = sample ? '0 : dwell_q + DW'(1);
    match_d     = match_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (!rs_low) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = rs_idx;
            if (DEBOUNCE_CNT == 1) begin
              key_code_d  = {rs_idx, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              match_d     = '0;
              state_d     = ST_HELD;
            end else begin
              match_d = MW'(1);
              state_d = ST_DEBOUNCE;
            end
          end
        end
      end

      ST_DEBOUNCE: begin
        if (sample) begin
          if (row_hit) begin
            if (match_q == MATCH_LAST) begin
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              match_d     = '0;
              state_d     = ST_HELD;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            // Bounce or a different key: give up on this column and move on.
            match_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
      end

      ST_HELD: begin
        // Only the captured row matters; other keys on this column are ignored.
        if (sample && cap_high) begin
          if (DEBOUNCE_CNT == 1) begin
            key_held_d = 1'b0;
            match_d    = '0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = ST_SCAN;
          end else begin
            match_d = MW'(1);
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (sample) begin
          if (cap_high) begin
            if (match_q == MATCH_LAST) begin
              key_held_d = 1'b0;
              match_d    = '0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = ST_SCAN;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            state_d = ST_HELD;
          end
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase

    col_d = col_drive(col_idx_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      dwell_q     <= '0;
      match_q     <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      match_q     <= match_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=2.
`timescale 1ns/1ps
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'b1111;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_vec = 0;
  int n_err = 0;

  keypad_scan #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock cycles, ending on a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reset, check reset outputs, release on a falling edge (cycle 0, dwell 0).
  task automatic do_reset();
    rst = 1'b1;
    row = 4'b1111;
    @(negedge clk);
    step(2);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    rst = 1'b0;
  endtask

  // Bounded wait for key_valid; returns cycles elapsed, or -1 on timeout.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cols [4];
    int lat;
    cols[0] = 4'b1110;
    cols[1] = 4'b1101;
    cols[2] = 4'b1011;
    cols[3] = 4'b0111;

    // Idle scan: column advances every 4 cycles, never a key_valid.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      chk("idle_col", col, cols[(k / 4) % 4]);
      chk("idle_valid", key_valid, 1'b0);
      step(1);
    end

    // Press row 2 on column 2, expect code A after 8 cycles.
    do_reset();
    step(8);
    chk("pre_col2", col, 4'b1011);
    row = 4'b1011;
    wait_valid(20, lat);
    chk("press_lat", lat, 8);
    chk("press_code", key_code, 4'hA);
    chk("press_held", key_held, 1'b1);
    step(1);
    chk("pulse_one", key_valid, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1);
      chk("held_col", col, 4'b1011);
      chk("held_valid", key_valid, 1'b0);
    end
    // One released sample point, then pressed again: still held.
    row = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("blip_held", key_held, 1'b1);
      chk("blip_valid", key_valid, 1'b0);
    end
    row = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("repress_held", key_held, 1'b1);
      chk("repress_valid", key_valid, 1'b0);
    end
    // Full release: held drops 8 cycles later, scan resumes on column 3.
    row = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("rel_held", key_held, 1'b1);
      chk("rel_col", col, 4'b1011);
    end
    step(1);
    chk("rel_done_held", key_held, 1'b0);
    chk("rel_done_col", col, 4'b0111);
    chk("rel_done_code", key_code, 4'hA);
    chk("rel_done_valid", key_valid, 1'b0);
    step(3);
    chk("resume_col3", col, 4'b0111);
    step(1);
    chk("resume_col0", col, 4'b1110);

    // Single-sample bounce on row 1, column 0: no key, scan moves on.
    do_reset();
    row = 4'b1101;
    for (int c = 1; c <= 11; c++) begin
      step(1);
      chk("bounce_col", col, (c < 8) ? 4'b1110 : 4'b1101);
      chk("bounce_valid", key_valid, 1'b0);
      if (c == 4) row = 4'b1111;
    end

    // Rows 0 and 3 together on column 1: lowest row wins, one pulse only.
    do_reset();
    step(4);
    chk("pre_col1", col, 4'b1101);
    row = 4'b0110;
    wait_valid(20, lat);
    chk("multi_lat", lat, 8);
    chk("multi_code", key_code, 4'h1);
    chk("multi_held", key_held, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("multi_no_second", key_valid, 1'b0);
      chk("multi_col", col, 4'b1101);
    end

    // Reset during debounce aborts; scanning restarts from sample at cycle 3.
    do_reset();
    row = 4'b1011;
    step(5);
    chk("deb_valid", key_valid, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_col", col, 4'b1110);
    chk("abort_code", key_code, 4'h0);
    chk("abort_valid", key_valid, 1'b0);
    chk("abort_held", key_held, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("in_rst_valid", key_valid, 1'b0);
      chk("in_rst_col", col, 4'b1110);
    end
    rst = 1'b0;
    wait_valid(20, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_code", key_code, 4'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
